// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the four-master bus arbiter: active-low grant levels,
// owner encodings and the owner-to-grant decode.
package bus_arbiter_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BUS_OWNER_W   = 2;
    localparam int BUS_MASTER_CH = 4;

    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'h0;
    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'h1;
    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'h2;
    localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'h3;

    // Active-low one-hot grant vector for a given owner.
    function automatic logic [BUS_MASTER_CH-1:0] grant_decode(
        input logic [BUS_OWNER_W-1:0] owner
    );
        logic [BUS_MASTER_CH-1:0] grnt;
        grnt        = {BUS_MASTER_CH{DISABLE_}};
        grnt[owner] = ENABLE_;
        return grnt;
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin search: first active-low request after the current owner,
// scanning owner+1..owner+3 (mod 4). The owner itself is never selected.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [BUS_OWNER_W-1:0]   owner,
    input  logic [BUS_MASTER_CH-1:0] req_,
    output logic [BUS_OWNER_W-1:0]   next_owner,
    output logic                     found
);

    logic [BUS_OWNER_W-1:0] cand;

    always_comb begin
        next_owner = owner;
        found      = 1'b0;
        cand       = owner;
        for (int i = 1; i < BUS_MASTER_CH; i++) begin
            cand = owner + BUS_OWNER_W'(i);
            if (!found && req_[cand] == ENABLE_) begin
                next_owner = cand;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with parked, always-valid grants.
// Optional hold timeout is compiled in with BUS_ARB_TIMEOUT_EN.
//
// owner | meaning
// ------+-----------------------------------------------
//   0   | master 0 drives the bus (reset / parked default)
//   1   | master 1 drives the bus
//   2   | master 2 drives the bus
//   3   | master 3 drives the bus
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD   = 64,
    parameter int HOLD_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m0_req_,
    input  logic                   m1_req_,
    input  logic                   m2_req_,
    input  logic                   m3_req_,
    output logic                   m0_grnt_,
    output logic                   m1_grnt_,
    output logic                   m2_grnt_,
    output logic                   m3_grnt_,
    output logic [BUS_OWNER_W-1:0] bus_owner
);

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 65535 || HOLD_CNT_W < 1 || HOLD_CNT_W > 31 ||
            (2 ** HOLD_CNT_W) < MAX_HOLD) begin : g_bad_param
            $error("bus_arbiter: illegal MAX_HOLD / HOLD_CNT_W combination");
        end
    endgenerate

    logic [BUS_MASTER_CH-1:0] req_vec_;
    logic [BUS_MASTER_CH-1:0] grnt_q;
    logic [BUS_OWNER_W-1:0]   owner_q;
    logic [BUS_OWNER_W-1:0]   pick_owner;
    logic [BUS_OWNER_W-1:0]   next_owner;
    logic                     others_wait;
    logic                     owner_req;
    logic                     owner_release;
    logic                     timeout;

    assign req_vec_  = {m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_req = req_vec_[owner_q];
    assign owner_release = (owner_req == DISABLE_);

    bus_arb_rr_pick u_rr_pick (
        .owner      (owner_q),
        .req_       (req_vec_),
        .next_owner (pick_owner),
        .found      (others_wait)
    );

    // With nobody else waiting the grant stays parked on the current owner.
    always_comb begin
        next_owner = owner_q;
        if ((owner_release || timeout) && others_wait)
            next_owner = pick_owner;
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic                  contended;

    assign contended = (owner_req == ENABLE_) && others_wait;
    assign timeout   = contended && (hold_cnt == HOLD_LAST);

    // A forced rotation changes the owner, which is what clears the counter.
    always_ff @(posedge clk) begin
        if (reset)
            hold_cnt <= '0;
        else if (next_owner != owner_q || !contended)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= BUS_OWNER_MASTER_0;
            grnt_q  <= grant_decode(BUS_OWNER_MASTER_0);
        end else begin
            owner_q <= next_owner;
            grnt_q  <= grant_decode(next_owner);
        end
    end

    assign m0_grnt_  = grnt_q[0];
    assign m1_grnt_  = grnt_q[1];
    assign m2_grnt_  = grnt_q[2];
    assign m3_grnt_  = grnt_q[3];
    assign bus_owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, release, rotation, parking,
// mid-operation reset and the hold timeout (when BUS_ARB_TIMEOUT_EN is set).
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] bus_owner;

    int tests_run = 0;
    int tests_failed = 0;

    bus_arbiter #(
        .MAX_HOLD   (4),
        .HOLD_CNT_W (16)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req_   (m0_req_),
        .m1_req_   (m1_req_),
        .m2_req_   (m2_req_),
        .m3_req_   (m3_req_),
        .m0_grnt_  (m0_grnt_),
        .m1_grnt_  (m1_grnt_),
        .m2_grnt_  (m2_grnt_),
        .m3_grnt_  (m3_grnt_),
        .bus_owner (bus_owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request vector is {m3,m2,m1,m0}, active low.
    task automatic set_req(input logic [3:0] r);
        m0_req_ = r[0];
        m1_req_ = r[1];
        m2_req_ = r[2];
        m3_req_ = r[3];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grants {m3..m0} expected as active-low one-hot of k; owner expected k.
    task automatic expect_owner(input string tag, input logic [1:0] k);
        logic [3:0] g;
        logic [3:0] exp_g;
        g     = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
        exp_g = 4'b1111;
        exp_g[k] = 1'b0;
        check({tag, "_grnt"}, {4'h0, g}, {4'h0, exp_g});
        check({tag, "_owner"}, {6'h0, bus_owner}, {6'h0, k});
    endtask

    initial begin
        reset = 1'b1;
        set_req(4'b0000);

        // Reset with everyone requesting: master 0 owns, then keeps it.
        step();
        step();
        expect_owner("reset", 2'd0);
        reset = 1'b0;
        step();
        expect_owner("hold0_a", 2'd0);
        step();
        expect_owner("hold0_b", 2'd0);

        // Single waiter: m0 releases, m2 requests.
        reset = 1'b1;
        set_req(4'b1110);
        step();
        reset = 1'b0;
        step();
        expect_owner("pre_rel", 2'd0);
        set_req(4'b1011);
        step();
        expect_owner("rel_m2", 2'd2);

        // Rotation: all request, the owner drops for one cycle each time.
        reset = 1'b1;
        set_req(4'b0000);
        step();
        reset = 1'b0;
        set_req(4'b0001);
        step();
        expect_owner("rot1", 2'd1);
        set_req(4'b0010);
        step();
        expect_owner("rot2", 2'd2);
        set_req(4'b0100);
        step();
        expect_owner("rot3", 2'd3);
        set_req(4'b1000);
        step();
        expect_owner("rot0", 2'd0);

        // Parking on master 3, then master 1 picks up the bus.
        set_req(4'b0111);
        step();
        expect_owner("to_m3", 2'd3);
        set_req(4'b1111);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_owner("park3", 2'd3);
        end
        check("one_hot_park", 8'($countones(~{m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_})), 8'd1);
        set_req(4'b1101);
        step();
        expect_owner("park_to_m1", 2'd1);

        // m1 releases with m0 and m3 waiting: rotation reaches 3 before 0.
        set_req(4'b0110);
        step();
        expect_owner("rr_skip0", 2'd3);
        set_req(4'b1011);
        step();
        expect_owner("to_m2", 2'd2);

        // Reset while m2 holds and everyone requests.
        set_req(4'b0000);
        reset = 1'b1;
        step();
        expect_owner("mid_reset", 2'd0);
        reset = 1'b0;
        step();
        expect_owner("post_reset", 2'd0);

        // Timeout: m1 owns from cycle 0, m3 waits throughout.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(4'b0101);
        step();
        expect_owner("to_c0", 2'd1);
        for (int c = 1; c <= 3; c++) begin
            step();
            expect_owner("to_hold", 2'd1);
        end
        step();
`ifdef BUS_ARB_TIMEOUT_EN
        expect_owner("to_c4", 2'd3);
`else
        expect_owner("to_c4", 2'd1);
        for (int c = 5; c <= 100; c++) step();
        expect_owner("to_c100", 2'd1);
`endif
        check("one_hot_end", 8'($countones(~{m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_})), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
